// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART byte serializer among NUM_REQ
//   byte producers. The winner's byte is latched and acknowledged with a
//   one-cycle gnt pulse. The byte is then launched with a one-cycle tx_start
//   pulse once the serializer is not busy. The arbiter waits for tx_done and
//   then idles for GAP_CLKS cycles before it arbitrates again.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : S_WAIT gives up after TIMEOUT_CLKS cycles without tx_done,
//                 pulses err_timeout and drops the byte.
//     undefined : S_WAIT waits indefinitely and err_timeout is tied 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [NUM_REQ]   req[i]=1: requester i holds a byte
//   req_data     in   [8*NUM_REQ] byte i at [8*i+7:8*i]
//   gnt          out  [NUM_REQ]   one-hot 1-cycle pulse: byte i taken
//   tx_start     out  1-cycle launch pulse to the serializer
//   tx_data      out  [8]  latched byte, stable from tx_start until tx_done
//   tx_busy      in   serializer busy, holds off tx_start
//   tx_done      in   1-cycle pulse, frame fully sent
//   owner        out  [IDX_W] index of the current/last winner
//   active       out  high in every state except S_IDLE
//   err_timeout  out  1-cycle pulse on S_WAIT timeout
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int IDX_W        = 2,
   parameter int GAP_CLKS     = 2,
   parameter int TIMEOUT_CLKS = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic [IDX_W-1:0]     owner,
   output logic                 active,
   output logic                 err_timeout
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) ||
       GAP_CLKS < 0 || GAP_CLKS > 15 ||
       TIMEOUT_CLKS < 1 || TIMEOUT_CLKS > 65535) begin : g_bad_params
      $error("uart_tx_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

   localparam int unsigned NREQ = NUM_REQ;
   // With GAP_CLKS==0 the gap state is skipped entirely.
   localparam state_t      S_AFTER  = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
   localparam logic [3:0]  GAP_LAST = 4'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [3:0]       gap_cnt;
   logic             found;
   logic [IDX_W-1:0] win;
   logic [7:0]       sel_byte;
   int unsigned      slot;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
   logic [15:0] wait_cnt;
`else
   assign err_timeout = 1'b0;
`endif

   assign active = (state != S_IDLE);

   // Search ptr+1, ptr+2, ... modulo NUM_REQ; the first set request wins,
   // so the previous winner is always examined last.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      slot     = 0;
      sel_byte = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         slot = 32'(ptr) + off;
         if (slot >= NREQ) slot = slot - NREQ;
         if (!found && req[IDX_W'(slot)]) begin
            found = 1'b1;
            win   = IDX_W'(slot);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == IDX_W'(i)) sel_byte = req_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ptr      <= IDX_W'(NUM_REQ - 1);
         gnt      <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         owner    <= '0;
         gap_cnt  <= '0;
`ifdef ARB_TIMEOUT_EN
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         gnt      <= '0;
         tx_start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt[win] <= 1'b1;
                  tx_data  <= sel_byte;
                  owner    <= win;
                  ptr      <= win;
                  state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state    <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            S_WAIT: begin
               // tx_done takes precedence over a timeout in the same cycle.
               if (tx_done) begin
                  gap_cnt <= '0;
                  state   <= S_AFTER;
               end
`ifdef ARB_TIMEOUT_EN
               else if (wait_cnt == TIMEOUT_LAST) begin
                  err_timeout <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= S_AFTER;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_IDLE;
               else                     gap_cnt <= gap_cnt + 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
